change_dispenser: RTL and testbench

//  Downstream of the vending datapath. Takes the coin counts the datapath

---
 rtl/change_dispenser_if.sv | 30 +++
 rtl/change_dispenser.sv | 172 +++++++++++++++++
 tb/tb_change_dispenser.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - payout command, chute sensor and solenoid/status signals
interface change_dispenser_if #(
   parameter int CNT_W = 8
);
   logic             in_load;
   logic [CNT_W-1:0] in_change_1;
   logic [CNT_W-1:0] in_change_05;
   logic [CNT_W-1:0] in_change_025;
   logic             in_coin_sensed;
   logic             in_clear;
   logic             out_eject_1;
   logic             out_eject_05;
   logic             out_eject_025;
   logic             out_busy;
   logic             out_done;
   logic             out_fault;
   logic [CNT_W+1:0] out_remaining;

   modport master (
      output in_load, in_change_1, in_change_05, in_change_025, in_coin_sensed, in_clear,
      input  out_eject_1, out_eject_05, out_eject_025, out_busy, out_done, out_fault,
             out_remaining
   );

   modport slave (
      input  in_load, in_change_1, in_change_05, in_change_025, in_coin_sensed, in_clear,
      output out_eject_1, out_eject_05, out_eject_025, out_busy, out_done, out_fault,
             out_remaining
   );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out latched coin counts one solenoid pulse at a time
module change_dispenser #(
   parameter int CNT_W       = 8,
   parameter int PULSE_CYC   = 4,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input logic              in_clka,
   input logic              in_restart_n,
   change_dispenser_if.slave bus
);
   localparam int RW   = CNT_W + 2;
   localparam int TMAX = (TIMEOUT_CYC > PULSE_CYC)
                         ? ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC)
                         : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_EJECT, S_WAIT_SENSE, S_GAP, S_DONE, S_FAULT} state_t;
   typedef enum logic [1:0] {D_1, D_05, D_025} denom_t;

   state_t           state_q, state_d;
   denom_t           sel_q, sel_d;
   logic [CNT_W-1:0] cnt_1_q, cnt_1_d, cnt_05_q, cnt_05_d, cnt_025_q, cnt_025_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             flag_q, flag_d;
   logic             count_coin;
   logic             eject_1_q, eject_1_d, eject_05_q, eject_05_d, eject_025_q, eject_025_d;
   logic             busy_q, busy_d, done_q, done_d, fault_q, fault_d;
   logic [RW-1:0]    remaining_q, remaining_d;

   function automatic denom_t pick(input logic [CNT_W-1:0] c1, input logic [CNT_W-1:0] c05);
      if (c1 != '0)       return D_1;
      else if (c05 != '0) return D_05;
      else                return D_025;
   endfunction

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_1_d    = cnt_1_q;
      cnt_05_d   = cnt_05_q;
      cnt_025_d  = cnt_025_q;
      timer_d    = timer_q;
      flag_d     = flag_q;
      count_coin = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_load) begin
               cnt_1_d   = bus.in_change_1;
               cnt_05_d  = bus.in_change_05;
               cnt_025_d = bus.in_change_025;
               timer_d   = '0;
               flag_d    = 1'b0;
               if ((bus.in_change_1 | bus.in_change_05 | bus.in_change_025) == '0) begin
                  state_d = S_DONE;
               end else begin
                  sel_d   = pick(bus.in_change_1, bus.in_change_05);
                  state_d = S_EJECT;
               end
            end
         end
         S_EJECT: begin
            flag_d  = flag_q | bus.in_coin_sensed;
            timer_d = timer_q + TW'(1);
            if (timer_q == TW'(PULSE_CYC - 1)) begin
               timer_d = '0;
               if (flag_d) begin
                  count_coin = 1'b1;
                  state_d    = S_GAP;
               end else begin
                  state_d    = S_WAIT_SENSE;
               end
            end
         end
         S_WAIT_SENSE: begin
            timer_d = timer_q + TW'(1);
            if (bus.in_coin_sensed) begin
               count_coin = 1'b1;
               timer_d    = '0;
               state_d    = S_GAP;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               timer_d = '0;
               state_d = S_FAULT;
            end
         end
         S_GAP: begin
            timer_d = timer_q + TW'(1);
            if (timer_q == TW'(GAP_CYC - 1)) begin
               timer_d = '0;
               flag_d  = 1'b0;
               if ((cnt_1_q | cnt_05_q | cnt_025_q) == '0) begin
                  state_d = S_DONE;
               end else begin
                  sel_d   = pick(cnt_1_q, cnt_05_q);
                  state_d = S_EJECT;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      // A coin is credited exactly once, at the point its sensing is resolved
      if (count_coin) begin
         case (sel_q)
            D_1:     if (cnt_1_q != '0)   cnt_1_d   = cnt_1_q - CNT_W'(1);
            D_05:    if (cnt_05_q != '0)  cnt_05_d  = cnt_05_q - CNT_W'(1);
            default: if (cnt_025_q != '0) cnt_025_d = cnt_025_q - CNT_W'(1);
         endcase
      end

      if (bus.in_clear) begin
         state_d   = S_IDLE;
         cnt_1_d   = '0;
         cnt_05_d  = '0;
         cnt_025_d = '0;
         timer_d   = '0;
         flag_d    = 1'b0;
      end

      eject_1_d   = (state_d == S_EJECT) && (sel_d == D_1);
      eject_05_d  = (state_d == S_EJECT) && (sel_d == D_05);
      eject_025_d = (state_d == S_EJECT) && (sel_d == D_025);
      busy_d      = (state_d == S_EJECT) || (state_d == S_WAIT_SENSE) || (state_d == S_GAP);
      done_d      = (state_d == S_DONE);
      fault_d     = (state_d == S_FAULT);
      remaining_d = RW'(cnt_1_d) + RW'(cnt_05_d) + RW'(cnt_025_d);
   end

   always_ff @(posedge in_clka or negedge in_restart_n) begin
      if (!in_restart_n) begin
         state_q     <= S_IDLE;
         sel_q       <= D_1;
         cnt_1_q     <= '0;
         cnt_05_q    <= '0;
         cnt_025_q   <= '0;
         timer_q     <= '0;
         flag_q      <= 1'b0;
         eject_1_q   <= 1'b0;
         eject_05_q  <= 1'b0;
         eject_025_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_1_q     <= cnt_1_d;
         cnt_05_q    <= cnt_05_d;
         cnt_025_q   <= cnt_025_d;
         timer_q     <= timer_d;
         flag_q      <= flag_d;
         eject_1_q   <= eject_1_d;
         eject_05_q  <= eject_05_d;
         eject_025_q <= eject_025_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
         remaining_q <= remaining_d;
      end
   end

   assign bus.out_eject_1   = eject_1_q;
   assign bus.out_eject_05  = eject_05_q;
   assign bus.out_eject_025 = eject_025_q;
   assign bus.out_busy      = busy_q;
   assign bus.out_done      = done_q;
   assign bus.out_fault     = fault_q;
   assign bus.out_remaining = remaining_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench: expected pulses/done/fault queued, monitor compares
module tb_change_dispenser;
   localparam int CNT_W   = 8;
   localparam int K_PULSE = 0;
   localparam int K_DONE  = 1;
   localparam int K_FAULT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   change_dispenser_if #(.CNT_W(CNT_W)) bus ();

   change_dispenser #(.CNT_W(CNT_W), .PULSE_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(255)) dut (
      .in_clka     (clk),
      .in_restart_n(rst_n),
      .bus         (bus)
   );

   typedef struct {
      int kind;
      int denom;
      int width;
      int gap;
      int rem;
   } ev_t;

   ev_t  exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   chute_mode = 0;
   logic chute_prev = 1'b0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic expect_ev(input int k, input int d, input int w, input int g, input int r);
      ev_t e;
      e.kind = k; e.denom = d; e.width = w; e.gap = g; e.rem = r;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input int k, input int d, input int w, input int g, input int r);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind %0d, required none", k);
      end else begin
         e = exp_q.pop_front();
         check("ev_kind", k, e.kind);
         if (e.kind == K_PULSE) begin
            check("pulse_denom", d, e.denom);
            check("pulse_width", w, e.width);
         end
         if (e.gap >= 0) check("ev_gap", g, e.gap);
         check("ev_remaining", r, e.rem);
      end
   endtask

   function automatic int ejects();
      return int'({bus.out_eject_1, bus.out_eject_05, bus.out_eject_025});
   endfunction

   // Chute model: 1 = coin seen one clock after the pulse ends,
   // 2 = sensor chatters during the pulse plus once more in the gap
   initial begin
      logic cur;
      bus.in_coin_sensed = 1'b0;
      forever begin
         @(negedge clk);
         cur = bus.out_eject_1 | bus.out_eject_05 | bus.out_eject_025;
         case (chute_mode)
            1:       bus.in_coin_sensed = chute_prev && !cur;
            2:       bus.in_coin_sensed = cur ? !bus.in_coin_sensed : chute_prev;
            default: bus.in_coin_sensed = 1'b0;
         endcase
         chute_prev = cur;
      end
   end

   // Monitor: turns DUT output activity into events and checks them against the queue
   initial begin
      int   w = 0, quiet = 0, den = 0, rem_at = 0, gap_at = 0, code;
      logic prev_done = 1'b0, prev_fault = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            w = 0; quiet = 0; prev_done = 1'b0; prev_fault = 1'b0;
            continue;
         end
         if (bus.out_done && !prev_done) begin
            pop_cmp(K_DONE, 0, 0, quiet, int'(bus.out_remaining));
            check("done_busy", int'(bus.out_busy), 0);
         end
         if (bus.out_done && prev_done) begin
            total++; bad++;
            $display("FAIL done_width: got >1 cycle, required 1");
         end
         if (bus.out_fault && !prev_fault) pop_cmp(K_FAULT, 0, 0, quiet, int'(bus.out_remaining));
         prev_done  = bus.out_done;
         prev_fault = bus.out_fault;
         if (ejects() != 0) begin
            code = (ejects() == 4) ? 0 : (ejects() == 2) ? 1 : (ejects() == 1) ? 2 : 3;
            if (w == 0) begin
               den = code; rem_at = int'(bus.out_remaining); gap_at = quiet;
            end else if (code != den) begin
               den = 3;
            end
            w++;
            quiet = 0;
         end else begin
            if (w != 0) pop_cmp(K_PULSE, den, w, gap_at, rem_at);
            w = 0;
            quiet++;
         end
      end
   end

   task automatic load_counts(input int a, input int b, input int c);
      @(negedge clk);
      bus.in_load = 1'b1;
      bus.in_change_1 = CNT_W'(a); bus.in_change_05 = CNT_W'(b); bus.in_change_025 = CNT_W'(c);
      @(negedge clk);
      bus.in_load = 1'b0;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_load = 1'b0; bus.in_clear = 1'b0;
      bus.in_change_1 = '0; bus.in_change_05 = '0; bus.in_change_025 = '0;
      #1;
      check("rst_ejects", ejects(), 0);
      check("rst_busy", int'(bus.out_busy), 0);
      check("rst_fault", int'(bus.out_fault), 0);
      check("rst_remaining", int'(bus.out_remaining), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // 2/1/1 with the coin sensed after each pulse
      chute_mode = 1;
      expect_ev(K_PULSE, 0, 4, -1, 4);
      expect_ev(K_PULSE, 0, 4, 3, 3);
      expect_ev(K_PULSE, 1, 4, 3, 2);
      expect_ev(K_PULSE, 2, 4, 3, 1);
      expect_ev(K_DONE, 0, 0, 3, 0);
      load_counts(2, 1, 1);
      drain(200);

      // nothing owed: done right after the load cycle
      chute_mode = 0;
      expect_ev(K_DONE, 0, 0, -1, 0);
      load_counts(0, 0, 0);
      check("zero_done_cycle1", int'(bus.out_done), 1);
      check("zero_busy", int'(bus.out_busy), 0);
      drain(20);

      // coin never sensed: fault after the full timeout, load ignored, clear recovers
      expect_ev(K_PULSE, 0, 4, -1, 1);
      expect_ev(K_FAULT, 0, 0, 255, 1);
      load_counts(1, 0, 0);
      drain(400);
      load_counts(1, 1, 1);
      check("fault_sticky", int'(bus.out_fault), 1);
      check("fault_remaining", int'(bus.out_remaining), 1);
      check("fault_busy", int'(bus.out_busy), 0);
      check("fault_ejects", ejects(), 0);
      @(negedge clk); bus.in_clear = 1'b1;
      @(negedge clk); bus.in_clear = 1'b0;
      check("clear_fault", int'(bus.out_fault), 0);
      check("clear_remaining", int'(bus.out_remaining), 0);

      // load while busy is ignored
      chute_mode = 1;
      expect_ev(K_PULSE, 0, 4, -1, 3);
      expect_ev(K_PULSE, 0, 4, 3, 2);
      expect_ev(K_PULSE, 0, 4, 3, 1);
      expect_ev(K_DONE, 0, 0, 3, 0);
      load_counts(3, 0, 0);
      repeat (5) @(negedge clk);
      check("busy_mid_payout", int'(bus.out_busy), 1);
      bus.in_load = 1'b1;
      bus.in_change_1 = '0; bus.in_change_05 = CNT_W'(5); bus.in_change_025 = CNT_W'(5);
      @(negedge clk);
      bus.in_load = 1'b0;
      drain(200);

      // sensed during the pulse, chattering sensor: no WAIT_SENSE, one decrement per coin
      chute_mode = 2;
      expect_ev(K_PULSE, 0, 4, -1, 3);
      expect_ev(K_PULSE, 1, 4, 2, 2);
      expect_ev(K_PULSE, 2, 4, 2, 1);
      expect_ev(K_DONE, 0, 0, 2, 0);
      load_counts(1, 1, 1);
      drain(200);

      // asynchronous reset in the middle of a pulse
      chute_mode = 1;
      load_counts(2, 0, 0);
      @(negedge clk);
      check("pre_reset_eject", ejects(), 4);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ejects", ejects(), 0);
      check("async_rst_busy", int'(bus.out_busy), 0);
      check("async_rst_remaining", int'(bus.out_remaining), 0);
      chute_mode = 0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", int'(bus.out_busy), 0);
      check("post_rst_remaining", int'(bus.out_remaining), 0);

      // clear and load together: clear wins
      bus.in_load = 1'b1; bus.in_clear = 1'b1;
      bus.in_change_1 = CNT_W'(1); bus.in_change_05 = CNT_W'(1); bus.in_change_025 = CNT_W'(1);
      @(negedge clk);
      bus.in_load = 1'b0; bus.in_clear = 1'b0;
      check("clr_load_busy", int'(bus.out_busy), 0);
      check("clr_load_ejects", ejects(), 0);
      check("clr_load_remaining", int'(bus.out_remaining), 0);
      check("clr_load_done", int'(bus.out_done), 0);
      repeat (3) @(negedge clk);
      check("clr_load_still_idle", int'(bus.out_busy), 0);

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
